// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: default pixel width,
// the scheduler state type and a width helper.
package cnn_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StEmit,
        StDone
    } sched_state_e;

    // $clog2 that never returns 0, so single-entry counters still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/patch_buffer.sv
// Frame store for the patch scheduler: one write port and one synchronous
// read port; the read register holds its value while re_i is low.
module patch_buffer #(
    parameter int unsigned DEPTH  = 81,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = cnn_pkg::clog2_min1(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so the output bus is defined after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/patch_scheduler.sv
// Buffers a raster-order frame, then streams it back as FILTER_SIZE x FILTER_SIZE
// patches, tile by tile, with ready/valid flow control on both sides.
module patch_scheduler #(
    parameter int unsigned  SIZE        = 9,
    parameter int unsigned  FILTER_SIZE = 3,
    parameter int unsigned  DATA_W      = cnn_pkg::DATA_W,
    localparam int unsigned NT          = SIZE / FILTER_SIZE,
    localparam int unsigned TW          = cnn_pkg::clog2_min1(NT * NT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [TW-1:0]     out_tile,
    output logic              out_first,
    output logic              out_last,
    output logic              out_frame_last,
    output logic              busy,
    output logic              done
);

    import cnn_pkg::*;

    localparam int unsigned NPIX = SIZE * SIZE;
    localparam int unsigned AW   = clog2_min1(NPIX);
    localparam int unsigned NW   = clog2_min1(NT);
    localparam int unsigned FW   = clog2_min1(FILTER_SIZE);

    sched_state_e state_q, state_d;

    logic [AW-1:0] pix_q, pix_d;
    logic [TW-1:0] iss_t_q, iss_t_d;
    logic [NW-1:0] iss_tr_q, iss_tr_d, iss_tc_q, iss_tc_d;
    logic [FW-1:0] iss_i_q, iss_i_d, iss_j_q, iss_j_d;
    logic          iss_done_q, iss_done_d;

    logic          out_valid_q, out_valid_d;
    logic [TW-1:0] out_tile_q, out_tile_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;
    logic          out_frame_last_q, out_frame_last_d;

    logic          in_hs, out_hs, adv, issue;
    logic          last_i, last_j, last_tc, last_t;
    logic [AW-1:0] rd_addr;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: if (in_hs && pix_q == AW'(NPIX - 1)) state_d = StEmit;
            StEmit: if (out_hs && out_frame_last_q) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    // ---------------- issue counters and output stage ----------------
    // The element register advances whenever it is empty or being consumed, so
    // a read issued this cycle lands in the buffer's read register next cycle.
    assign adv     = !out_valid_q || out_ready;
    assign issue   = (state_q == StEmit) && !iss_done_q && adv;
    assign last_i  = (iss_i_q == FW'(FILTER_SIZE - 1));
    assign last_j  = (iss_j_q == FW'(FILTER_SIZE - 1));
    assign last_tc = (iss_tc_q == NW'(NT - 1));
    assign last_t  = (iss_t_q == TW'(NT * NT - 1));

    assign rd_addr = AW'((32'(iss_tr_q) * FILTER_SIZE + 32'(iss_i_q)) * SIZE
                         + 32'(iss_tc_q) * FILTER_SIZE + 32'(iss_j_q));

    always_comb begin
        pix_d            = pix_q;
        iss_t_d          = iss_t_q;
        iss_tr_d         = iss_tr_q;
        iss_tc_d         = iss_tc_q;
        iss_i_d          = iss_i_q;
        iss_j_d          = iss_j_q;
        iss_done_d       = iss_done_q;
        out_valid_d      = out_valid_q;
        out_tile_d       = out_tile_q;
        out_first_d      = out_first_q;
        out_last_d       = out_last_q;
        out_frame_last_d = out_frame_last_q;

        if (state_q == StIdle || state_q == StDone) begin
            pix_d      = '0;
            iss_t_d    = '0;
            iss_tr_d   = '0;
            iss_tc_d   = '0;
            iss_i_d    = '0;
            iss_j_d    = '0;
            iss_done_d = 1'b0;
        end

        if (in_hs) begin
            pix_d = pix_q + AW'(1);
        end

        if (issue) begin
            if (!last_j) begin
                iss_j_d = iss_j_q + FW'(1);
            end else begin
                iss_j_d = '0;
                if (!last_i) begin
                    iss_i_d = iss_i_q + FW'(1);
                end else begin
                    iss_i_d = '0;
                    if (last_t) begin
                        iss_done_d = 1'b1;
                    end else begin
                        iss_t_d = iss_t_q + TW'(1);
                        if (last_tc) begin
                            iss_tc_d = '0;
                            iss_tr_d = iss_tr_q + NW'(1);
                        end else begin
                            iss_tc_d = iss_tc_q + NW'(1);
                        end
                    end
                end
            end
        end

        if (adv) begin
            out_valid_d      = issue;
            out_tile_d       = issue ? iss_t_q : out_tile_q;
            out_first_d      = issue && (iss_i_q == '0) && (iss_j_q == '0);
            out_last_d       = issue && last_i && last_j;
            out_frame_last_d = issue && last_i && last_j && last_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q            <= '0;
            iss_t_q          <= '0;
            iss_tr_q         <= '0;
            iss_tc_q         <= '0;
            iss_i_q          <= '0;
            iss_j_q          <= '0;
            iss_done_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_tile_q       <= '0;
            out_first_q      <= 1'b0;
            out_last_q       <= 1'b0;
            out_frame_last_q <= 1'b0;
        end else begin
            pix_q            <= pix_d;
            iss_t_q          <= iss_t_d;
            iss_tr_q         <= iss_tr_d;
            iss_tc_q         <= iss_tc_d;
            iss_i_q          <= iss_i_d;
            iss_j_q          <= iss_j_d;
            iss_done_q       <= iss_done_d;
            out_valid_q      <= out_valid_d;
            out_tile_q       <= out_tile_d;
            out_first_q      <= out_first_d;
            out_last_q       <= out_last_d;
            out_frame_last_q <= out_frame_last_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tile       = out_tile_q;
    assign out_first      = out_first_q;
    assign out_last       = out_last_q;
    assign out_frame_last = out_frame_last_q;

    patch_buffer #(
        .DEPTH  (NPIX),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_buffer (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (in_hs),
        .waddr_i (pix_q),
        .wdata_i (in_data),
        .re_i    (issue),
        .raddr_i (rd_addr),
        .rdata_o (out_data)
    );

endmodule

// File: tb/tb_patch_scheduler.sv
// Directed bench for patch_scheduler: a SIZE=9 and a SIZE=10 instance share
// the stimulus bus; sel picks which one is driven and observed.
module tb_patch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start9, start10;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    bit          sel;

    logic        in_ready9, out_valid9, first9, last9, flast9, busy9, done9;
    logic [31:0] out_data9;
    logic [3:0]  out_tile9;
    logic        in_ready10, out_valid10, first10, last10, flast10, busy10, done10;
    logic [31:0] out_data10;
    logic [3:0]  out_tile10;

    logic        o_in_ready, o_valid, o_first, o_last, o_flast, o_busy, o_done;
    logic [31:0] o_data;
    logic [3:0]  o_tile;

    int errors = 0;
    int checks = 0;
    int got_data [0:127];

    always #5 clk = ~clk;

    patch_scheduler #(.SIZE(9), .FILTER_SIZE(3), .DATA_W(32)) dut9 (
        .clk(clk), .rst(rst), .start(start9), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready9), .out_valid(out_valid9), .out_data(out_data9),
        .out_ready(out_ready), .out_tile(out_tile9), .out_first(first9), .out_last(last9),
        .out_frame_last(flast9), .busy(busy9), .done(done9)
    );

    patch_scheduler #(.SIZE(10), .FILTER_SIZE(3), .DATA_W(32)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready10), .out_valid(out_valid10), .out_data(out_data10),
        .out_ready(out_ready), .out_tile(out_tile10), .out_first(first10), .out_last(last10),
        .out_frame_last(flast10), .busy(busy10), .done(done10)
    );

    assign o_in_ready = sel ? in_ready10  : in_ready9;
    assign o_valid    = sel ? out_valid10 : out_valid9;
    assign o_data     = sel ? out_data10  : out_data9;
    assign o_tile     = sel ? out_tile10  : out_tile9;
    assign o_first    = sel ? first10     : first9;
    assign o_last     = sel ? last10      : last9;
    assign o_flast    = sel ? flast10     : flast9;
    assign o_busy     = sel ? busy10      : busy9;
    assign o_done     = sel ? done10      : done9;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start10 = v;
        else     start9  = v;
    endtask

    task automatic run_frame(input int size, input bit gaps, input bit rnd,
                             input bit poke, input int abort_tile);
        int          nt   = size / 3;
        int          npix = size * size;
        int          nel  = nt * nt * 9;
        int          hs   = 0;
        int          idx  = 0;
        int          cyc  = 0;
        int          t, e, tr, tc, exp_val;
        bit          stalled = 1'b0;
        logic [31:0] h_data;
        logic [6:0]  h_meta, exp_meta;

        set_start(1'b1);
        step();
        set_start(1'b0);
        check_eq("load_busy", {o_busy, o_in_ready}, 2'b11);

        while (hs < npix && cyc < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = hs;
            set_start(poke && cyc == 5);
            if (in_valid && o_in_ready) hs++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        set_start(1'b0);
        check_eq("load_count", hs, npix);
        check_eq("lat_cycle1_valid", o_valid, 1'b0);
        check_eq("emit_in_ready", o_in_ready, 1'b0);
        step();
        check_eq("lat_cycle2_valid", o_valid, 1'b1);

        cyc = 0;
        while (idx < nel && cyc < 20000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_start(poke && cyc == 10);
            if (stalled) begin
                check_eq("stall_valid", o_valid, 1'b1);
                check_eq("stall_data", o_data, h_data);
                check_eq("stall_meta", {o_tile, o_first, o_last, o_flast}, h_meta);
            end
            if (!rnd) check_eq("no_bubble", o_valid, 1'b1);
            if (o_valid) begin
                if (abort_tile >= 0 && int'(o_tile) == abort_tile) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check_eq("abort_flags", {o_busy, o_valid, o_in_ready, o_done}, 4'b0000);
                    check_eq("abort_data", {o_data, o_tile}, 36'h0);
                    return;
                end
                if (out_ready) begin
                    t        = idx / 9;
                    e        = idx % 9;
                    tr       = t / nt;
                    tc       = t % nt;
                    exp_val  = (tr * 3 + e / 3) * size + tc * 3 + e % 3;
                    exp_meta = {4'(t), e == 0, e == 8, e == 8 && t == nt * nt - 1};
                    check_eq("elem_data", o_data, exp_val);
                    check_eq("elem_meta", {o_tile, o_first, o_last, o_flast}, exp_meta);
                    got_data[idx] = int'(o_data);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_data  = o_data;
                    h_meta  = {o_tile, o_first, o_last, o_flast};
                end
            end
            step();
            cyc++;
        end
        set_start(1'b0);
        out_ready = 1'b1;
        check_eq("emit_count", idx, nel);
        check_eq("done_pulse", {o_done, o_busy, o_valid}, 3'b110);
        step();
        check_eq("done_clear", {o_done, o_busy}, 2'b00);
    endtask

    task automatic spot9();
        check_eq("t0_e0", got_data[0], 0);
        check_eq("t0_e3", got_data[3], 9);
        check_eq("t0_e8", got_data[8], 20);
        check_eq("t4_e0", got_data[36], 30);
        check_eq("t4_e5", got_data[41], 41);
        check_eq("t4_e8", got_data[44], 50);
        check_eq("t8_e8", got_data[80], 80);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start9    = 1'b0;
        start10   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        sel       = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("reset_flags9", {o_busy, o_in_ready, o_valid, o_done, o_first, o_last, o_flast},
                 7'b0);
        check_eq("reset_bus9", {o_data, o_tile}, 36'h0);
        step();
        check_eq("idle_no_start", o_busy, 1'b0);

        run_frame(9, 1'b0, 1'b0, 1'b0, -1);
        spot9();
        run_frame(9, 1'b1, 1'b1, 1'b1, -1);
        spot9();
        run_frame(9, 1'b0, 1'b0, 1'b0, 3);
        step();
        run_frame(9, 1'b0, 1'b0, 1'b0, -1);
        spot9();

        sel = 1'b1;
        step();
        check_eq("reset_flags10", {o_busy, o_in_ready, o_valid, o_done}, 4'b0);
        run_frame(10, 1'b1, 1'b0, 1'b0, -1);
        check_eq("s10_t0_e0", got_data[0], 0);
        check_eq("s10_t0_e3", got_data[3], 10);
        check_eq("s10_t1_e0", got_data[9], 3);
        check_eq("s10_t8_e8", got_data[80], 88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
